// File: rtl/dbus_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbus_responder_pkg
// Description : Shared types for the data-bus responder. This package holds
//               the request/response structs, the access-size enum, the
//               responder state enum, the counter width, and the
//               misalignment helper function.
// Revision    : 1.0 - initial release
// ============================================================================
package dbus_responder_pkg;

  // Width of the latency down-counter. It covers LATENCY up to 15.
  localparam int RESP_LAT_W = 4;

  // Access size, encoded as log2 of the byte count.
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } resp_state_t;

  // An access is misaligned when the address is not a multiple of its size.
  function automatic logic is_misaligned(input logic [63:0] addr, input msize_t size);
    logic [63:0] mask;
    mask = (64'd1 << size) - 64'd1;
    return (addr & mask) != 64'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dbus_responder_mem.sv
`default_nettype none
// ============================================================================
// Module      : dbus_resp_mem
// Description : Word-organised, byte-strobed synchronous RAM (64-bit words).
//               The read is registered and updates only when re is high, so
//               rdata holds its value between reads. A write replaces only
//               the bytes whose strobe bit is set.
// Ports       : clk    - clock, rising edge
//               index  - word index
//               strobe - byte write enables
//               wdata  - write data
//               we     - write enable
//               re     - read enable; loads rdata
//               rdata  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_resp_mem #(
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] index,
  input  logic [7:0]               strobe,
  input  logic [63:0]              wdata,
  input  logic                     we,
  input  logic                     re,
  output logic [63:0]              rdata
);

  // There is no reset. Contents are initialised or preloaded from outside
  // through this array.
  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe[i]) begin
          mem[index][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[index];
    end
  end

endmodule
`default_nettype wire

// File: rtl/dbus_responder.sv
`default_nettype none
// ============================================================================
// Module      : dbus_responder
// Description : Memory-side endpoint for the dbus request/response handshake.
//               It handles one request at a time. Each request completes
//               exactly LATENCY cycles after it is first seen in IDLE, with a
//               one-cycle addr_ok/data_ok pulse. Writes commit at the edge
//               that ends DONE. The read data in DONE is the pre-write word.
// Config      : Define DBUS_RESPONDER_ALIGN_CHECK_EN to flag misaligned
//               accesses. A flagged access suppresses its write, returns
//               data 0, and raises err in DONE. When the macro is undefined,
//               err is tied 0.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous, active-low reset
//               dreq  - request (valid, addr, size, strobe, data)
//               dresp - response (addr_ok, data_ok, data)
//               err   - misaligned-access flag, pulses with data_ok
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err
);

  localparam int                    IDX_W    = $clog2(DEPTH);
  localparam logic [RESP_LAT_W-1:0] CNT_LOAD = RESP_LAT_W'(LATENCY - 1);

  resp_state_t           state_q, state_d;
  logic [RESP_LAT_W-1:0] cnt_q, cnt_d;

  // Latched request fields. The live bus is not used after the request is sampled.
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  strobe_q;
  msize_t      size_q;
  logic        mis_q;
  // Forces the visible read data to zero. It is set on reset and after a
  // misaligned access.
  logic        zero_q;

  logic             req_mis;
  logic             take;
  logic             mis_now;
  logic             mem_re;
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [63:0]      mem_rdata;

`ifdef DBUS_RESPONDER_ALIGN_CHECK_EN
  assign req_mis = is_misaligned(dreq.addr, dreq.size);
`else
  assign req_mis = 1'b0;
`endif

  assign take = (state_q == IDLE) && dreq.valid;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (dreq.valid) begin
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - RESP_LAT_W'(1);
        if (cnt_q == RESP_LAT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------- request latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      strobe_q <= '0;
      size_q   <= MSIZE1;
      mis_q    <= 1'b0;
    end else if (take) begin
      addr_q   <= dreq.addr;
      wdata_q  <= dreq.data;
      strobe_q <= dreq.strobe;
      size_q   <= dreq.size;
      mis_q    <= req_mis;
    end
  end

  // ------------------------------------------------------- memory control
  // The RAM read happens on the edge that enters DONE, so the registered
  // word is valid in DONE. For LATENCY=1 that edge is the sampling edge
  // itself, so the index and misalignment come from the live bus in IDLE.
  assign mem_re  = (state_d == DONE) && (state_q != DONE);
  assign mem_idx = (state_q == IDLE) ? dreq.addr[3 +: IDX_W] : addr_q[3 +: IDX_W];
  assign mis_now = (state_q == IDLE) ? req_mis : mis_q;
  // The write commits on the edge that ends DONE. An asynchronous reset
  // during DONE clears state_q first, which cancels the write.
  assign mem_we  = (state_q == DONE) && (strobe_q != 8'h00) && !mis_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zero_q <= 1'b1;
    end else if (mem_re) begin
      zero_q <= mis_now;
    end
  end

  dbus_resp_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk    (clk),
    .index  (mem_idx),
    .strobe (strobe_q),
    .wdata  (wdata_q),
    .we     (mem_we),
    .re     (mem_re),
    .rdata  (mem_rdata)
  );

  // -------------------------------------------------------------- outputs
  always_comb begin
    dresp         = '0;
    dresp.addr_ok = (state_q == DONE);
    dresp.data_ok = (state_q == DONE);
    dresp.data    = zero_q ? 64'd0 : mem_rdata;
  end

  assign err = (state_q == DONE) && mis_q;

  // Upper address bits alias, and size is only used by the alignment check.
  logic unused_ok;
  assign unused_ok = ^{addr_q, size_q};

endmodule
`default_nettype wire

// File: tb/tb_dbus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbus_responder
// Description : Self-checking bench for dbus_responder. The bench
//               instantiates two responders: index 0 has LATENCY=2 and
//               index 1 has LATENCY=1. Expected results come from a
//               word/byte memory model kept inside the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbus_responder;
  import dbus_responder_pkg::*;

`ifdef DBUS_RESPONDER_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  dbus_req_t  req    [2];
  dbus_resp_t resp   [2];
  logic       err_w  [2];

  int errors = 0;
  int checks = 0;

  // Reference memory: instance x word index 0..15, plus a flag for known words.
  logic [63:0] mdl   [2][16];
  bit          known [2][16];

  dbus_responder #(.DEPTH(4096), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(rst_n), .dreq(req[0]), .dresp(resp[0]), .err(err_w[0]));
  dbus_responder #(.DEPTH(64), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .dreq(req[1]), .dresp(resp[1]), .err(err_w[1]));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
    bit          chk_data;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tbl [9];

  function automatic int lat_of(input int s);
    return (s == 0) ? 2 : 1;
  endfunction

  function automatic bit exp_mis(input logic [63:0] addr, input msize_t size);
    return ALIGN_EN && ((addr % (64'd1 << size)) != 64'd0);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data,
                                        input logic [7:0] strobe);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (strobe[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one request and hold it until data_ok, then drop it. The task
  // returns the latency in cycles, measured from the first sampling cycle
  // (-1 if data_ok never arrives).
  task automatic access(input int s, input logic [63:0] addr, input msize_t size,
                        input logic [7:0] strobe, input logic [63:0] data,
                        output logic [63:0] rdata, output logic rerr, output int lat);
    logic aok;
    @(posedge clk); #1;
    req[s] = '{valid: 1'b1, addr: addr, size: size, strobe: strobe, data: data};
    lat = -1; rdata = '0; rerr = 1'b0; aok = 1'b0;
    for (int k = 0; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (resp[s].data_ok) begin
        lat = k; rdata = resp[s].data; rerr = err_w[s]; aok = resp[s].addr_ok;
      end
    end
    chk("addr_ok_with_data_ok", {63'd0, aok}, 64'd1);
    @(posedge clk); #1;
    req[s].valid = 1'b0;
  endtask

  initial begin
    logic [63:0] rd;
    logic        re;
    int          lat;
    req[0] = '0;
    req[1] = '0;

    // ---- reset and idle outputs
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        chk("idle_flags", {61'd0, resp[s].addr_ok, resp[s].data_ok, err_w[s]}, 64'd0);
        chk("idle_data", resp[s].data, 64'd0);
      end
    end

    // ---- table-driven directed accesses on the LATENCY=2 instance
    tbl[0] = '{64'h8000_0010, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, 0, 64'd0, 1'b0};
    tbl[1] = '{64'h8000_0010, MSIZE8, 8'h00, 64'd0, 1, 64'h1122_3344_5566_7788, 1'b0};
    tbl[2] = '{64'h8000_0010, MSIZE8, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 1,
               64'h1122_3344_5566_7788, 1'b0};
    tbl[3] = '{64'h8000_0010, MSIZE8, 8'h00, 64'd0, 1, 64'h1122_3344_BBBB_BBBB, 1'b0};
    tbl[4] = '{64'h0000_0010, MSIZE8, 8'h00, 64'd0, 1, 64'h1122_3344_BBBB_BBBB, 1'b0};
    tbl[5] = '{64'h8000_0000, MSIZE8, 8'hFF, 64'hCAFE_F00D_1234_5678, 0, 64'd0, 1'b0};
    tbl[6] = '{64'h8000_0002, MSIZE4, 8'h3C, 64'hDEAD_BEEF_0BAD_F00D, 1,
               ALIGN_EN ? 64'd0 : 64'hCAFE_F00D_1234_5678, ALIGN_EN};
    tbl[7] = '{64'h8000_0000, MSIZE8, 8'h00, 64'd0, 1,
               ALIGN_EN ? 64'hCAFE_F00D_1234_5678 : 64'hCAFE_BEEF_0BAD_5678, 1'b0};
    tbl[8] = '{64'h8000_0020, MSIZE8, 8'hFF, 64'd0, 0, 64'd0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      access(0, tbl[i].addr, tbl[i].size, tbl[i].strobe, tbl[i].data, rd, re, lat);
      chk("tbl_latency", 64'(lat), 64'd2);
      chk("tbl_err", {63'd0, re}, {63'd0, tbl[i].exp_err});
      if (tbl[i].chk_data) chk("tbl_data", rd, tbl[i].exp_data);
    end

    // ---- valid dropped during WAIT: the latched write still completes
    @(posedge clk); #1;
    req[0] = '{valid: 1'b1, addr: 64'h8000_0028, size: MSIZE8, strobe: 8'hFF,
               data: 64'h0123_4567_89AB_CDEF};
    @(posedge clk); #1;
    req[0].valid = 1'b0;
    @(negedge clk); chk("drop_wait_dok", {63'd0, resp[0].data_ok}, 64'd0);
    @(negedge clk); chk("drop_done_dok", {63'd0, resp[0].data_ok}, 64'd1);
    access(0, 64'h8000_0028, MSIZE8, 8'h00, 64'd0, rd, re, lat);
    chk("drop_readback", rd, 64'h0123_4567_89AB_CDEF);

    // ---- reset asserted in WAIT of a write: no completion, no write
    @(posedge clk); #1;
    req[0] = '{valid: 1'b1, addr: 64'h8000_0020, size: MSIZE8, strobe: 8'hFF,
               data: 64'h5555_AAAA_5555_AAAA};
    @(posedge clk); #1;
    req[0].valid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 1) rst_n = 1'b1;
      chk("abort_flags", {62'd0, resp[0].data_ok, err_w[0]}, 64'd0);
      chk("abort_data", resp[0].data, 64'd0);
    end
    access(0, 64'h8000_0020, MSIZE8, 8'h00, 64'd0, rd, re, lat);
    chk("abort_readback", rd, 64'd0);

    // ---- randomized accesses against the model (word indices 8..15)
    for (int s = 0; s < 2; s++) begin
      for (int idx = 8; idx < 16; idx++) begin
        logic [63:0] d;
        d = {$urandom(), $urandom()};
        access(s, 64'h8000_0000 | 64'(idx << 3), MSIZE8, 8'hFF, d, rd, re, lat);
        chk("init_latency", 64'(lat), 64'(lat_of(s)));
        mdl[s][idx] = d;
        known[s][idx] = 1'b1;
      end
    end
    for (int n = 0; n < 60; n++) begin
      int          s, idx, sz, off;
      logic [63:0] a, d;
      logic [7:0]  stb;
      bit          mis;
      s   = int'($urandom_range(0, 1));
      idx = int'($urandom_range(8, 15));
      sz  = int'($urandom_range(0, 3));
      off = int'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) off = off & ~((1 << sz) - 1);
      a   = {32'($urandom()), 32'h0} | 64'(idx << 3) | 64'(off);
      d   = {$urandom(), $urandom()};
      stb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
      mis = exp_mis(a, msize_t'(sz));
      access(s, a, msize_t'(sz), stb, d, rd, re, lat);
      chk("rand_latency", 64'(lat), 64'(lat_of(s)));
      chk("rand_err", {63'd0, re}, {63'd0, mis});
      if (known[s][idx]) chk("rand_data", rd, mis ? 64'd0 : mdl[s][idx]);
      if (stb != 8'h00 && !mis) mdl[s][idx] = merge(mdl[s][idx], d, stb);
    end

    // ---- LATENCY=1 back-to-back reads with valid held high throughout
    @(posedge clk); #1;
    req[1] = '{valid: 1'b1, addr: 64'h8000_0040, size: MSIZE8, strobe: 8'h00, data: 64'd0};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("b2b_dok", {63'd0, resp[1].data_ok}, {63'd0, c[0]});
      if (c[0]) chk("b2b_data", resp[1].data, mdl[1][8 + c/2]);
      @(posedge clk); #1;
      if (c[0]) req[1].addr = 64'h8000_0000 | 64'((8 + c/2 + 1) << 3);
    end
    req[1].valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
